signed_to_digits: RTL
=====================

# signed_to_digits

Sequential binary-to-display-code converter. It takes a signed two's-complement value, such as a calculator operand or result, and produces one 4-bit display code per 7-segment position. Each code feeds a per-digit `displayOperand` decoder directly. Conversion uses a multi-cycle shift-and-add-3 (double dabble) with a start/busy/done handshake. The output applies leading-zero blanking and places a floating minus sign.

## Interface
- `WIDTH`, default 8: width of the signed input.
- `DIGITS`, default 3: number of magnitude digit positions. Must satisfy 10^DIGITS > 2^(WIDTH-1).
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request a conversion of `value`. Sampled only in IDLE.
- `value`, input, WIDTH: signed two's-complement operand. Captured on the accepting edge.
- `busy`, output, 1: high while a conversion is in progress.
- `done`, output, 1: one-cycle pulse when `digits` has been updated.
- `digits`, output, 4*(DIGITS+1): display codes. Position i occupies bits [4i+3:4i]; position 0 is the rightmost.

## Operation
- Display codes:
  - 4'h0–4'h9: decimal digit.
  - 4'hF: minus sign.
  - 4'hA: blank, which the decoder renders as all segments off.
  - No other codes are ever emitted.
- FSM states are IDLE, CONV and FORMAT.
- IDLE:
  - If `start`=1, capture sign = `value`[WIDTH-1] and magnitude = |`value|`, held in WIDTH bits.
  - Clear the BCD accumulator (4*DIGITS bits) and bit counter, then go to CONV.
  - If `start`=0, stay in IDLE.
- CONV: on each edge:
  - Add 3 to every BCD nibble ≥ 5.
  - Shift {BCD, magnitude} left by 1.
  - Increment the counter.
  - After exactly WIDTH shifts, go to FORMAT.
- FORMAT: in one edge:
  - Write `digits`, pulse `done`, drop `busy`, and go to IDLE.
- Formatting rules:
  - Let m be the index of the most significant nonzero BCD digit. If magnitude is 0, m = 0.
  - Positions 0..m carry their BCD digit. Position 0 shows 0 when the value is 0.
  - Positions above m are blank, except as below.
  - If sign=1, position m+1 is 4'hF. Position DIGITS is therefore used only by a minus sign.
- Arithmetic:
  - The most negative input, -2^(WIDTH-1), converts correctly. Its magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits.
  - Zero never shows a minus sign.
- Handshake and output holding:
  - `start` is ignored while `busy`=1; there is no queuing.
  - `value` may change freely after the accepting edge.
  - `digits` holds its last value until the next FORMAT edge. It never shows intermediate BCD.
- Reset:
  - Asserting `reset` at any time forces IDLE, `busy`=0, `done`=0, and all positions of `digits` = 4'hA.
  - An interrupted conversion is discarded and produces no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `digits`={(DIGITS+1){4'hA}}, state IDLE, internal registers 0.
- Accept edge k is an edge where the state is IDLE and `start`=1.
  - `busy`=1 after edge k.
  - The CONV shifts occur on edges k+1 .. k+WIDTH.
  - FORMAT occurs on edge k+WIDTH+1. After it, `digits` is valid, `done`=1 and `busy`=0.
- Latency: `done` rises WIDTH+1 edges after the accept edge, which is 9 edges for WIDTH=8.
- `done` is high for exactly one cycle.
- The earliest next accept is edge k+WIDTH+2. With `start` held high, a conversion completes every WIDTH+2 cycles.
- All outputs are registered, with no combinational path from input to output.
- Reset release takes effect on the first clock edge after deassertion, at which point the state is IDLE.

## Test plan
All cases use WIDTH=8, DIGITS=3. `digits` is listed as positions 3..0.
- Reset and zero:
  - After reset, `digits`=A,A,A,A and `busy`=`done`=0.
  - Then start with `value`=0 → A,A,A,0.
  - `done` pulses exactly 9 edges after the accept edge.
- Extremes:
  - 127 → A,1,2,7.
  - -128 (8'h80) → F,1,2,8.
  - -1 → A,A,F,1.
- Floating minus and internal zeros:
  - -40 → A,F,4,0.
  - -5 → A,A,F,5.
  - 100 → A,1,0,0.
- Busy rejection:
  - Start 45, then pulse `start` with `value`=-99 during CONV.
  - Result is only A,A,4,5 with a single `done`, and `busy` stays high throughout.
- Back-to-back:
  - Hold `start`=1, presenting 9 and then -9.
  - `done` pulses 10 cycles apart. Outputs are A,A,A,9 and then A,A,F,9.
  - `digits` holds A,A,A,9 between the two pulses.
- Reset mid-conversion:
  - Start -77 and assert `reset` 4 cycles later.
  - `digits`=A,A,A,A, no `done`, `busy`=0.
  - A subsequent start with 12 gives A,A,1,2.

Source files
------------

// File: rtl/signed_to_digits.sv
// Signed binary to 7-segment display codes via double dabble,
// with leading-zero blanking and a floating minus sign.
module signed_to_digits #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS+3:0]   digits
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] BLANK = 4'hA;
  localparam logic [3:0] MINUS = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FORMAT
  } state_t;

  state_t                state;
  logic                  sign;
  logic [WIDTH-1:0]      mag;
  logic [4*DIGITS-1:0]   bcd;
  logic [CW-1:0]         cnt;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS+3:0]   fmt;
  int                    m;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // m is the top nonzero digit; zero keeps m = 0 so a single 0 shows
  always_comb begin
    m = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0)
        m = i;
    end
    fmt = {(DIGITS+1){BLANK}};
    for (int i = 0; i <= DIGITS; i++) begin
      if (i < DIGITS && i <= m)
        fmt[4*i +: 4] = bcd[4*i +: 4];
      else if (sign && i == m + 1)
        fmt[4*i +: 4] = MINUS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sign   <= 1'b0;
      mag    <= '0;
      bcd    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      digits <= {(DIGITS+1){BLANK}};
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign  <= value[WIDTH-1];
            mag   <= value[WIDTH-1] ? (~value + 1'b1) : value;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          bcd <= {adj[4*DIGITS-2:0], mag[WIDTH-1]};
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FORMAT;
        end
        FORMAT: begin
          digits <= fmt;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
